// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Shifts and rotates take one bit per cycle; MUL is shift-add.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             shift_flag,
  output logic             zero_flag,
  output logic             neg_flag
);

  localparam int SAW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_ADC = 4'b0110;
  localparam logic [3:0] OP_ROL = 4'b0111;
  localparam logic [3:0] OP_ROR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

  localparam logic [SAW:0] CNT_ONE = 1;
  localparam logic [SAW:0] CNT_W   = (SAW+1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [SAW:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               shift_q, shift_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_reg_q, carry_reg_d;

  logic [SAW-1:0]     amt;
  logic               is_shift;
  logic               fin;
  logic               res_ok;
  logic [WIDTH-1:0]   res_fin;
  logic               c_fin;
  logic               s_fin;
  logic [WIDTH-1:0]   step;
  logic               sout;
  logic [2*WIDTH-1:0] acc_n;

  assign amt = B[SAW-1:0];
  assign is_shift = (opcode == OP_SHL) || (opcode == OP_SHR) ||
                    (opcode == OP_ROL) || (opcode == OP_ROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      shift_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_reg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      shift_q     <= shift_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_reg_q <= carry_reg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (amt != '0)) state_d = S_SHIFT;
          else if (opcode == OP_MUL)   state_d = S_MUL;
          else                         state_d = S_DONE;
        end
      end
      S_SHIFT: if (cnt_q == CNT_ONE) state_d = S_DONE;
      S_MUL:   if (cnt_q == CNT_ONE) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    carry_d     = carry_q;
    shift_d     = shift_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_reg_d = carry_reg_q;
    fin         = 1'b0;
    res_ok      = 1'b1;
    res_fin     = '0;
    c_fin       = 1'b0;
    s_fin       = 1'b0;
    step        = result_q;
    sout        = 1'b0;
    acc_n       = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = opcode;
          fin  = 1'b1;
          case (opcode)
            OP_ADD: {c_fin, res_fin} = {1'b0, A} + {1'b0, B};
            OP_SUB: {c_fin, res_fin} = {1'b0, A} - {1'b0, B};
            OP_ADC: {c_fin, res_fin} = {1'b0, A} + {1'b0, B}
                                     + {{WIDTH{1'b0}}, carry_reg_q};
            OP_AND: res_fin = A & B;
            OP_OR:  res_fin = A | B;
            OP_XOR: res_fin = A ^ B;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
              res_fin = A;
              if (amt != '0) begin
                fin      = 1'b0;
                result_d = A;
                cnt_d    = {1'b0, amt};
              end
            end
            OP_MUL: begin
              fin      = 1'b0;
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, A};
              mplier_d = B;
              cnt_d    = CNT_W;
            end
            default: res_ok = 1'b0;
          endcase
        end
      end
      S_SHIFT: begin
        case (op_q)
          OP_SHL: begin
            step = {result_q[WIDTH-2:0], 1'b0};
            sout = result_q[WIDTH-1];
          end
          OP_SHR: begin
            step = {1'b0, result_q[WIDTH-1:1]};
            sout = result_q[0];
          end
          OP_ROL: begin
            step = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            sout = result_q[WIDTH-1];
          end
          OP_ROR: begin
            step = {result_q[0], result_q[WIDTH-1:1]};
            sout = result_q[0];
          end
          default: step = result_q;
        endcase
        result_d = step;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          fin     = 1'b1;
          res_fin = step;
          s_fin   = sout;
        end
      end
      S_MUL: begin
        acc_n    = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_n;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          fin     = 1'b1;
          res_fin = acc_n[WIDTH-1:0];
          c_fin   = |acc_n[2*WIDTH-1:WIDTH];
        end
      end
      S_DONE: begin
        if (out_ready && ((op_q == OP_ADD) || (op_q == OP_SUB) ||
                          (op_q == OP_ADC)))
          carry_reg_d = carry_q;
      end
      default: ;
    endcase
    // NOP reports all flags low, including zero, despite its zero result
    if (fin) begin
      result_d = res_fin;
      carry_d  = c_fin;
      shift_d  = s_fin;
      zero_d   = res_ok && (res_fin == '0);
      neg_d    = res_fin[WIDTH-1];
    end
  end

  assign result     = result_q;
  assign carry_flag = carry_q;
  assign shift_flag = shift_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8.
// Expected values are hand-computed from the operation definitions.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_flag;
  logic       shift_flag;
  logic       zero_flag;
  logic       neg_flag;

  int n_cmp;
  int n_fail;

  alu_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_flag (carry_flag),
    .shift_flag (shift_flag),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input int lat_exp);
    int lat;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    opcode   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
  endtask

  task automatic chk_res(input string tag, input logic [7:0] r,
                         input logic c, input logic s,
                         input logic z, input logic n);
    chk({tag, " result"}, 32'(result), 32'(r));
    chk({tag, " carry"},  32'(carry_flag), 32'(c));
    chk({tag, " shift"},  32'(shift_flag), 32'(s));
    chk({tag, " zero"},   32'(zero_flag), 32'(z));
    chk({tag, " neg"},    32'(neg_flag), 32'(n));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    opcode    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk_res("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    run_op("add", 4'b0000, 8'hF0, 8'h20, 1);
    chk_res("add", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    take("add");
    run_op("adc", 4'b0110, 8'h01, 8'h01, 1);
    chk_res("adc", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    take("adc");

    run_op("sub_lt", 4'b0001, 8'h10, 8'h20, 1);
    chk_res("sub_lt", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
    take("sub_lt");
    run_op("sub_eq", 4'b0001, 8'h20, 8'h20, 1);
    chk_res("sub_eq", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    take("sub_eq");

    run_op("shl", 4'b0100, 8'h81, 8'h03, 4);
    chk_res("shl", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    take("shl");
    run_op("shr", 4'b0101, 8'h81, 8'h01, 2);
    chk_res("shr", 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    take("shr");
    run_op("ror", 4'b1000, 8'h01, 8'h01, 2);
    chk_res("ror", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    take("ror");
    run_op("rol", 4'b0111, 8'h81, 8'h01, 2);
    chk_res("rol", 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    take("rol");
    run_op("shl_n0", 4'b0100, 8'h5A, 8'h08, 1);
    chk_res("shl_n0", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    take("shl_n0");

    run_op("mul_ovf", 4'b1001, 8'h10, 8'h10, 9);
    chk_res("mul_ovf", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    take("mul_ovf");
    run_op("mul", 4'b1001, 8'h0F, 8'h03, 9);
    chk_res("mul", 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0);
    take("mul");

    run_op("and", 4'b0010, 8'hCC, 8'hAA, 1);
    chk_res("and", 8'h88, 1'b0, 1'b0, 1'b0, 1'b1);
    take("and");
    run_op("or", 4'b0011, 8'h0C, 8'h03, 1);
    chk_res("or", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    take("or");
    run_op("nop", 4'b1111, 8'hFF, 8'hFF, 1);
    chk_res("nop", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    take("nop");

    run_op("xor_hold", 4'b1010, 8'h5A, 8'hFF, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_res("hold", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      chk("hold out_valid", 32'(out_valid), 32'd1);
    end
    take("xor_hold");

    run_op("add_c", 4'b0000, 8'hFF, 8'h01, 1);
    chk_res("add_c", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    take("add_c");
    opcode   = 4'b1001;
    A        = 8'h0F;
    B        = 8'h03;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mul busy out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    run_op("adc_rst", 4'b0110, 8'h01, 8'h01, 1);
    chk_res("adc_rst", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    take("adc_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
